// File: rtl/bus_sel_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bus_sel_pkg: shared bus-source code definitions for encoder/decoder
// Rev 1.0
// ------------------------------------------------------------------
package bus_sel_pkg;

  localparam int SEL_W = 5;
  localparam int OUT_W = 32;
  localparam logic [SEL_W-1:0] SRC_NONE = 5'h1F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic is_valid_src(input logic [SEL_W-1:0] code, input int num_src);
    return (int'(code) < num_src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec_5_32.sv
`default_nettype none
// ------------------------------------------------------------------
// onehot_dec_5_32: combinational binary-to-one-hot source decoder
// Rev 1.0
// ------------------------------------------------------------------
module onehot_dec_5_32
  import bus_sel_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  output logic [OUT_W-1:0] o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/bus_source_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// bus_source_decoder: handshake-fed registered one-hot bus drive
// enable with fixed hold time and break-before-make gap.  Rev 1.0
// ------------------------------------------------------------------
module bus_source_decoder
  import bus_sel_pkg::*;
#(
  parameter int NUM_SRC     = 24,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  output logic [OUT_W-1:0] drive_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [HCW-1:0]   r_hold_cnt;
  logic [HCW-1:0]   w_hold_nxt;
  logic [GCW-1:0]   r_gap_cnt;
  logic [GCW-1:0]   w_gap_nxt;
  logic [OUT_W-1:0] r_drive_en;
  logic [OUT_W-1:0] w_drive_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [OUT_W-1:0] w_dec;
  logic             w_accept;

  onehot_dec_5_32 u_dec (
    .i_sel    (req_sel),
    .o_onehot (w_dec)
  );

  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_drive_nxt = r_drive_en;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_sel == SRC_NONE) begin
            w_done_nxt = 1'b1;
          end else if (is_valid_src(req_sel, NUM_SRC)) begin
            w_state_nxt = DRIVE;
            w_drive_nxt = w_dec;
            w_hold_nxt  = HOLD_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (r_hold_cnt == '0) begin
          // The done cycle is always a zero cycle, so break-before-make holds even without a gap.
          w_drive_nxt = '0;
          w_done_nxt  = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_gap_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt - HCW'(1);
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GCW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_drive_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_drive_en <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_drive_en <= w_drive_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign drive_en  = r_drive_en;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_source_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bus_source_decoder: scoreboard bench; instance 0 has GAP=1,
// instance 1 has GAP=0.  Rev 1.0
// ------------------------------------------------------------------
module tb_bus_source_decoder;
  import bus_sel_pkg::*;

  localparam int HOLD    = 2;
  localparam int NSRC    = 24;
  localparam int GAP_I0  = 1;
  localparam int GAP_I1  = 0;

  typedef struct {
    logic [31:0] drv;
    logic        done;
    logic        err;
    logic        busy;
    logic        ready;
  } exp_t;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] drv;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  s0 = '0, s1 = '0;
  logic        rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [31:0] drv0, drv1;

  exp_t q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus_source_decoder #(.NUM_SRC(NSRC), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP_I0)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .req_valid(v0), .req_ready(rdy0), .req_sel(s0),
    .drive_en(drv0), .busy(busy0), .done(done0), .err(err0)
  );

  bus_source_decoder #(.NUM_SRC(NSRC), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP_I1)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .req_valid(v1), .req_ready(rdy1), .req_sel(s1),
    .drive_en(drv1), .busy(busy1), .done(done1), .err(err1)
  );

  // Invariants: drive_en zero or one-hot, done and err exclusive.
  always @(negedge clk) begin
    if (clr_n) begin
      checks++;
      if (!$onehot0(drv0) || !$onehot0(drv1) || (done0 && err0) || (done1 && err1)) begin
        failures++;
        $display("FAIL invariant: drv0=%h drv1=%h done0=%b err0=%b done1=%b err1=%b, required one-hot-or-zero and done/err exclusive",
                 drv0, drv1, done0, err0, done1, err1);
      end
    end
  end

  task automatic check_now(input int inst, input exp_t e, input string name);
    logic [31:0] d;
    logic dn, er, bz, rd;
    if (inst == 0) begin d = drv0; dn = done0; er = err0; bz = busy0; rd = rdy0; end
    else           begin d = drv1; dn = done1; er = err1; bz = busy1; rd = rdy1; end
    checks++;
    if ({d, dn, er, bz, rd} !== {e.drv, e.done, e.err, e.busy, e.ready}) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t: drive_en=%h done=%b err=%b busy=%b ready=%b, expected drive_en=%h done=%b err=%b busy=%b ready=%b",
               name, inst, $time, d, dn, er, bz, rd, e.drv, e.done, e.err, e.busy, e.ready);
    end
  endtask

  task automatic push_expect(input logic [4:0] sel, input logic [31:0] exp_drv, input int gap);
    exp_t e;
    if (sel == 5'h1F) begin
      e = '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1}; q.push_back(e);
    end else if (int'(sel) >= NSRC) begin
      e = '{32'h0, 1'b0, 1'b1, 1'b0, 1'b1}; q.push_back(e);
    end else begin
      for (int i = 0; i < HOLD; i++) begin
        e = '{exp_drv, 1'b0, 1'b0, 1'b1, 1'b0}; q.push_back(e);
      end
      e = '{32'h0, 1'b1, 1'b0, logic'(gap > 0), logic'(gap == 0)}; q.push_back(e);
      if (gap > 0) begin
        for (int i = 1; i < gap; i++) begin
          e = '{32'h0, 1'b0, 1'b0, 1'b1, 1'b0}; q.push_back(e);
        end
        e = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1}; q.push_back(e);
      end
    end
  endtask

  task automatic drain(input int inst, input string name);
    exp_t e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check_now(inst, e, name);
    end
  endtask

  task automatic send(input int inst, input logic [4:0] sel, input logic [31:0] exp_drv, input string name);
    int n = 0;
    @(negedge clk);
    while (((inst == 0) ? rdy0 : rdy1) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout inst%0d: req_ready=0 for 50 cycles, expected 1", name, inst);
      return;
    end
    if (inst == 0) begin v0 = 1'b1; s0 = sel; end else begin v1 = 1'b1; s1 = sel; end
    @(posedge clk);
    #1;
    if (inst == 0) v0 = 1'b0; else v1 = 1'b0;
    push_expect(sel, exp_drv, (inst == 0) ? GAP_I0 : GAP_I1);
    drain(inst, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vecs[0] = '{5'd5,  32'h0000_0020};
    vecs[1] = '{5'd0,  32'h0000_0001};
    vecs[2] = '{5'd24, 32'h0000_0000};
    vecs[3] = '{5'd23, 32'h0080_0000};
    vecs[4] = '{5'd30, 32'h0000_0000};
    vecs[5] = '{5'h1F, 32'h0000_0000};
    vecs[6] = '{5'd17, 32'h0002_0000};
    vecs[7] = '{5'd1,  32'h0000_0002};

    // Reset state while clr_n is low.
    #12;
    e = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_now(0, e, "reset_hold");
    check_now(1, e, "reset_hold");
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check_now(0, e, "post_reset");
    check_now(1, e, "post_reset");

    for (int inst = 0; inst < 2; inst++) begin
      for (int k = 0; k < 8; k++) begin
        send(inst, vecs[k].sel, vecs[k].drv, "table");
      end
    end

    // Back-to-back on the GAP=0 instance with valid held.
    @(negedge clk);
    v1 = 1'b1; s1 = 5'd3;
    @(posedge clk); #1;
    s1 = 5'd4;
    push_expect(5'd3, 32'h0000_0008, GAP_I1);
    drain(1, "b2b_first");
    @(posedge clk); #1;
    v1 = 1'b0;
    push_expect(5'd4, 32'h0000_0010, GAP_I1);
    drain(1, "b2b_second");

    // Input churn while driving source 2.
    @(negedge clk);
    v0 = 1'b1; s0 = 5'd2;
    @(posedge clk); #1;
    s0 = 5'd9;
    push_expect(5'd2, 32'h0000_0004, GAP_I0);
    drain(0, "churn_src2");
    @(posedge clk); #1;
    v0 = 1'b0;
    push_expect(5'd9, 32'h0000_0200, GAP_I0);
    drain(0, "churn_src9");

    // Asynchronous reset in the middle of DRIVE on source 7.
    @(negedge clk);
    v0 = 1'b1; s0 = 5'd7;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    e = '{32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b0};
    check_now(0, e, "pre_reset_drive");
    #2;
    clr_n = 1'b0;
    #1;
    e = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_now(0, e, "async_reset_drop");
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now(0, e, "after_reset_idle");
    end
    send(0, 5'd11, 32'h0000_0800, "recover");

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
